// File: rtl/decoder_scan_nxm_pkg.sv
// Shared definitions for the scanning one-hot decoder: state encodings,
// mode constants and the onehot() helper used by decoder_scan_nxm.
package decoder_scan_nxm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest decoder supported is ADDR_W=5, so a 32-bit result covers every build;
   // callers truncate to NUM_OUT bits. Out-of-range indices decode to all zeros.
   function automatic logic [31:0] onehot(input logic [4:0] index, input int num_out);
      logic [31:0] r;
      r = '0;
      if (int'(index) < num_out) r[index] = 1'b1;
      return r;
   endfunction

endpackage : decoder_scan_nxm_pkg

// File: rtl/decoder_scan_nxm_prescaler.sv
// Scan-rate prescaler: counts 0..PRESCALE-1 while run=1 and flags the
// terminal count with a single-cycle tick. clr or rst restarts the count.
module decoder_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   // With PRESCALE=1 the count is pinned at 0, so tick fires every running cycle.
   assign tick = run && (cnt == TERM);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (run) begin
         if (tick) cnt <= '0;
         else      cnt <= cnt + CW'(1);
      end
   end

endmodule : decoder_prescaler

// File: rtl/decoder_scan_nxm.sv
// Registered ADDR_W-to-NUM_OUT one-hot decoder with direct and scan modes.
// Build option: define DECODER_ACTIVE_LOW_EN for an active-low D output.
module decoder_scan_nxm
   import decoder_scan_nxm_pkg::*;
#(
   parameter int ADDR_W   = 2,
   parameter int NUM_OUT  = 4,
   parameter int PRESCALE = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic               load,
   input  logic [ADDR_W-1:0]  addr,
   output logic [NUM_OUT-1:0] D,
   output logic [ADDR_W-1:0]  sel_idx,
   output logic               wrap,
   output logic               err
);

`ifdef DECODER_ACTIVE_LOW_EN
   localparam logic [NUM_OUT-1:0] INACTIVE = '1;
`else
   localparam logic [NUM_OUT-1:0] INACTIVE = '0;
`endif

   localparam logic [ADDR_W:0]   NUM_OUT_V = (ADDR_W + 1)'(NUM_OUT);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_OUT - 1);

   state_t              state, nxt;
   logic [NUM_OUT-1:0]  d_hi_nxt;
   logic [ADDR_W-1:0]   sel_nxt;
   logic                wrap_nxt, err_nxt;

   logic [NUM_OUT-1:0]  oh_addr, oh_sel, oh_step, oh_zero;
   logic [ADDR_W-1:0]   step_idx;
   logic                addr_ok;
   logic                scan_run, scan_tick;

   assign addr_ok  = ({1'b0, addr} < NUM_OUT_V);
   assign step_idx = (sel_idx == LAST_IDX) ? '0 : sel_idx + ADDR_W'(1);
   assign oh_addr  = NUM_OUT'(onehot(5'(addr), NUM_OUT));
   assign oh_sel   = NUM_OUT'(onehot(5'(sel_idx), NUM_OUT));
   assign oh_step  = NUM_OUT'(onehot(5'(step_idx), NUM_OUT));
   assign oh_zero  = NUM_OUT'(onehot(5'd0, NUM_OUT));

   // The prescaler only runs while the FSM stays in SCAN; the entry edge clears it.
   assign scan_run = (state == ST_SCAN) && (nxt == ST_SCAN);

   decoder_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (!scan_run),
      .run  (scan_run),
      .tick (scan_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt      = state;
      d_hi_nxt = D ^ INACTIVE;
      sel_nxt  = sel_idx;
      wrap_nxt = 1'b0;
      err_nxt  = 1'b0;

      if (!en)                       nxt = ST_IDLE;
      else if (mode == MODE_DIRECT)  nxt = ST_DIRECT;
      else                           nxt = ST_SCAN;

      case (nxt)
         ST_IDLE: begin
            d_hi_nxt = '0;
         end
         ST_DIRECT: begin
            // A load on the entry edge takes precedence over resuming the old index.
            if (load) begin
               if (addr_ok) begin
                  sel_nxt  = addr;
                  d_hi_nxt = oh_addr;
               end else begin
                  d_hi_nxt = '0;
                  err_nxt  = 1'b1;
               end
            end else if (state != ST_DIRECT) begin
               d_hi_nxt = oh_sel;
            end
         end
         ST_SCAN: begin
            if (state != ST_SCAN) begin
               sel_nxt  = '0;
               d_hi_nxt = oh_zero;
            end else if (scan_tick) begin
               sel_nxt  = step_idx;
               d_hi_nxt = oh_step;
               wrap_nxt = (sel_idx == LAST_IDX);
            end
         end
         default: begin
            d_hi_nxt = '0;
         end
      endcase
   end

   // Polarity is folded in before the register so D comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         D       <= INACTIVE;
         sel_idx <= '0;
         wrap    <= 1'b0;
         err     <= 1'b0;
      end else begin
         D       <= d_hi_nxt ^ INACTIVE;
         sel_idx <= sel_nxt;
         wrap    <= wrap_nxt;
         err     <= err_nxt;
      end
   end

endmodule : decoder_scan_nxm
